posit_extract_pipe: RTL and testbench



---
 rtl/posit_pkg.sv | 32 +++
 rtl/posit_run_detect.sv | 33 +++
 rtl/posit_extract_pipe.sv | 117 +++++++++++
 tb/tb_posit_extract_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Purpose: shared width helpers and special-value patterns for the posit decode/encode datapath.
// Latency: n/a (package: constant functions only).
// Backpressure: n/a.
// Contents: rw(n) regime width, mw(n,es) mantissa width incl. hidden bit,
//           zero_pat() / nar_pat(n) constant bit patterns (up to MAX_N bits, truncate at use).
package posit_pkg;

    localparam int MAX_N = 64;

    // Signed regime k spans -(n-1)..n-2, which needs clog2(n)+1 bits.
    function automatic int rw(input int n);
        return $clog2(n) + 1;
    endfunction

    // Hidden bit plus the longest possible fraction (regime is at least 2 bits long).
    function automatic int mw(input int n, input int es);
        return n - es - 2;
    endfunction

    function automatic logic [MAX_N-1:0] zero_pat();
        return '0;
    endfunction

    // NaR is a lone 1 in the sign position.
    function automatic logic [MAX_N-1:0] nar_pat(input int n);
        logic [MAX_N-1:0] p;
        p = '0;
        p[n-1] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/posit_run_detect.sv
// Purpose: measure the regime run of a posit body (bits below the sign).
// Latency: combinational.
// Backpressure: none (pure function of its input).
// Ports: bits     - body[N-2:0], magnitude without the sign bit
//        run_len  - m, count of leading bits equal to bits[N-2], N-1 when no terminator
//        term_pos - index in bits of the terminating bit, -1 when the run reaches the LSB
module posit_run_detect
    import posit_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = rw(N)
) (
    input  logic [N-2:0]        bits,
    output logic [RW-1:0]       run_len,
    output logic signed [RW-1:0] term_pos
);

    logic stop;

    always_comb begin
        run_len = '0;
        stop    = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (bits[i] == bits[N-2])) begin
                run_len = run_len + RW'(1);
            end else begin
                stop = 1'b1;
            end
        end
        term_pos = RW'(N - 2) - run_len;
    end

endmodule

// File: rtl/posit_extract_pipe.sv
// Purpose: two-stage posit field extractor (sign, regime k, exponent, mantissa, zero/NaR).
// Latency: result registered two edges after the input word (S1 then S2).
// Backpressure: valid/ready; holds up to two words, in_ready drops only when both stages are full and out_ready is low.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_posit input stream;
//        out_valid/out_ready output stream with sign, regime (signed k), exponent, mantissa, is_zero, is_nar.
module posit_extract_pipe
    import posit_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RW = rw(N),
    parameter int MW = mw(N, ES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign,
    output logic signed [RW-1:0] regime,
    output logic [ES-1:0]        exponent,
    output logic [MW-1:0]        mantissa,
    output logic                 is_zero,
    output logic                 is_nar
);

    localparam logic [N-1:0] ZERO = N'(zero_pat());
    localparam logic [N-1:0] NAR  = N'(nar_pat(N));
    localparam logic [N-2:0] ONE  = (N-1)'(1);

    logic         s1_valid;
    logic         s1_sign;
    logic         s1_zero;
    logic         s1_nar;
    logic [N-2:0] s1_body;
    logic         s2_valid;
    logic         s1_load;
    logic         s2_load;

    logic [RW-1:0]        run_len;
    logic signed [RW-1:0] term_pos;
    logic signed [RW-1:0] k;
    logic [RW-1:0]        sh;
    logic [N-4:0]         tail;

    // S2 is the output register; it frees up whenever the consumer takes it.
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    posit_run_detect #(.N(N), .RW(RW)) u_run (
        .bits     (s1_body),
        .run_len  (run_len),
        .term_pos (term_pos)
    );

    // Everything after the terminator is exponent then fraction. The top two body
    // bits always belong to the regime, so shifting body[N-4:0] left by m-1
    // (= N-3-term_pos) lands the first post-terminator bit at tail's MSB and
    // fills vacated LSBs with zeros, which covers the truncated-exponent case.
    always_comb begin
        k    = s1_body[N-2] ? (run_len - RW'(1)) : (RW'(0) - run_len);
        sh   = RW'(N - 3) - term_pos;
        tail = s1_body[N-4:0] << sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_body  <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_sign  <= in_posit[N-1];
            // Low N-1 bits of the two's complement depend only on the low N-1 input bits.
            s1_body  <= in_posit[N-1] ? (~in_posit[N-2:0] + ONE) : in_posit[N-2:0];
            s1_zero  <= (in_posit == ZERO);
            s1_nar   <= (in_posit == NAR);
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            sign     <= 1'b0;
            regime   <= '0;
            exponent <= '0;
            mantissa <= '0;
            is_zero  <= 1'b0;
            is_nar   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            sign     <= s1_sign;
            is_zero  <= s1_zero;
            is_nar   <= s1_nar;
            if (s1_zero || s1_nar) begin
                regime   <= '0;
                exponent <= '0;
                mantissa <= '0;
            end else begin
                regime   <= k;
                exponent <= tail[N-4 -: ES];
                mantissa <= {1'b1, tail[MW-2:0]};
            end
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_posit_extract_pipe.sv
module tb_posit_extract_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic               iv8, ir8, ov8, or8, s8, z8, n8;
    logic [7:0]         p8;
    logic signed [3:0]  k8;
    logic [2:0]         e8, m8;
    logic [12:0]        o8;

    logic               iv16, ir16, ov16, or16, s16, z16, n16;
    logic [15:0]        p16;
    logic signed [4:0]  k16;
    logic [1:0]         e16;
    logic [11:0]        m16;
    logic [21:0]        o16;

    int checks = 0;
    int errors = 0;

    assign o8  = {s8, k8, e8, m8, z8, n8};
    assign o16 = {s16, k16, e16, m16, z16, n16};

    posit_extract_pipe #(.N(8), .ES(3)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(iv8), .in_ready(ir8), .in_posit(p8),
        .out_valid(ov8), .out_ready(or8),
        .sign(s8), .regime(k8), .exponent(e8), .mantissa(m8),
        .is_zero(z8), .is_nar(n8)
    );

    posit_extract_pipe #(.N(16), .ES(2)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(iv16), .in_ready(ir16), .in_posit(p16),
        .out_valid(ov16), .out_ready(or16),
        .sign(s16), .regime(k16), .exponent(e16), .mantissa(m16),
        .is_zero(z16), .is_nar(n16)
    );

    // Output transfers of the 8-bit instance, recorded at the transfer edge.
    logic [12:0] cap8[$];
    always @(posedge clk) begin
        if (!reset && ov8 && or8) cap8.push_back(o8);
    end

    function automatic logic [12:0] f8(input logic s, input int k, input int e, input int m,
                                       input logic z, input logic n);
        return {s, 4'(k), 3'(e), 3'(m), z, n};
    endfunction

    // Bit-serial reference decoder for N=16, ES=2.
    function automatic logic [21:0] ref16(input logic [15:0] p);
        logic [15:0] mag;
        logic        r0;
        logic [1:0]  e;
        logic [10:0] f;
        int          i, m, k;
        if (p == 16'h0000) return {1'b0, 5'd0, 2'd0, 12'd0, 1'b1, 1'b0};
        if (p == 16'h8000) return {1'b1, 5'd0, 2'd0, 12'd0, 1'b0, 1'b1};
        mag = p[15] ? (16'h0000 - p) : p;
        r0  = mag[14];
        i   = 14;
        m   = 0;
        while (i >= 0 && mag[i] == r0) begin
            m++;
            i--;
        end
        k = r0 ? (m - 1) : -m;
        i--;
        e = '0;
        for (int j = 0; j < 2; j++) begin
            e = {e[0], (i >= 0) ? mag[i] : 1'b0};
            i--;
        end
        f = '0;
        for (int j = 0; j < 11; j++) begin
            f = {f[9:0], (i >= 0) ? mag[i] : 1'b0};
            i--;
        end
        return {p[15], 5'(k), e, 1'b1, f, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single word through an idle pipe with out_ready high.
    task automatic one8(input string tag, input logic [7:0] w, input logic [12:0] exp);
        @(negedge clk);
        iv8 = 1'b1; p8 = w; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        chk({tag, "_not_yet"}, 32'(ov8), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(ov8), 32'd1);
        chk(tag, 32'(o8), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  bw [5];
        logic [12:0] be [5];
        logic [15:0] d16 [6];
        logic [21:0] q16[$];
        logic [21:0] obs16;
        logic        r, acc, xfer;
        int          idx, sent, got;

        reset = 1'b1;
        iv8 = 1'b0; p8 = '0; or8 = 1'b0;
        iv16 = 1'b0; p16 = '0; or16 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_data", 32'(o8), 32'd0);
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid16", 32'(ov16), 32'd0);

        // Directed decodes, N=8 ES=3.
        one8("zero",   8'h00, f8(0,  0, 0, 0, 1, 0));
        one8("nar",    8'h80, f8(1,  0, 0, 0, 0, 1));
        one8("pos_k0", 8'h50, f8(0,  0, 4, 4, 0, 0));
        one8("neg_k0", 8'hB0, f8(1,  0, 4, 4, 0, 0));
        one8("k_max",  8'h7F, f8(0,  6, 0, 4, 0, 0));
        one8("k_min",  8'h01, f8(0, -6, 0, 4, 0, 0));
        one8("k_m3",   8'h0B, f8(0, -3, 3, 4, 0, 0));
        one8("neg_k_min", 8'hFF, f8(1, -6, 0, 4, 0, 0));
        one8("frac",   8'h2D, f8(0, -1, 3, 5, 0, 0));

        // Backpressure: consumer stalled for 4 cycles while 5 words are offered.
        bw = '{8'h50, 8'hB0, 8'h7F, 8'h01, 8'h0B};
        be = '{f8(0, 0, 4, 4, 0, 0), f8(1, 0, 4, 4, 0, 0), f8(0, 6, 0, 4, 0, 0),
               f8(0, -6, 0, 4, 0, 0), f8(0, -3, 3, 4, 0, 0)};
        cap8.delete();
        idx = 0;
        or8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            iv8 = 1'b1; p8 = bw[idx];
            #1 r = ir8;
            @(posedge clk);
            if (r) idx++;
        end
        @(negedge clk);
        iv8 = 1'b1; p8 = bw[idx];
        #1;
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(ir8), 32'd0);
        chk("bp_out_valid", 32'(ov8), 32'd1);
        chk("bp_hold", 32'(o8), 32'(be[0]));
        chk("bp_nothing_out", 32'(cap8.size()), 32'd0);
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ir8), 32'd1);
        for (int c = 0; c < 40 && cap8.size() < 5; c++) begin
            iv8 = (idx < 5);
            if (idx < 5) p8 = bw[idx];
            #1 r = ir8;
            @(posedge clk);
            if (iv8 && r) idx++;
            @(negedge clk);
        end
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_all_sent", 32'(idx), 32'd5);
        chk("bp_out_count", 32'(cap8.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap8.size()) chk($sformatf("bp_order%0d", i), 32'(cap8[i]), 32'(be[i]));
        end
        chk("bp_drained", 32'(ov8), 32'd0);

        // Reset with both stages full: the flushed words must never appear.
        cap8.delete();
        idx = 0;
        or8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            iv8 = (idx < 2); p8 = bw[idx];
            #1 r = ir8;
            @(posedge clk);
            if (iv8 && r) idx++;
        end
        @(negedge clk);
        iv8 = 1'b0;
        #1;
        chk("rst_mid_full", 32'(ov8 && !ir8), 32'd1);
        reset = 1'b1; iv8 = 1'b1; p8 = 8'h7F; or8 = 1'b1;
        @(negedge clk);
        reset = 1'b0; iv8 = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(ov8), 32'd0);
        chk("rst_mid_data", 32'(o8), 32'd0);
        chk("rst_mid_in_ready", 32'(ir8), 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_emit", 32'(cap8.size()), 32'd0);
        chk("rst_mid_idle", 32'(ov8), 32'd0);

        // N=16 ES=2: directed head followed by random words and random out_ready.
        d16 = '{16'h4000, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            @(negedge clk);
            if (sent < 1000) begin
                iv16 = (sent < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                p16  = (sent < 6) ? d16[sent] : 16'($urandom);
            end else begin
                iv16 = 1'b0;
            end
            or16 = ($urandom_range(0, 3) != 0);
            #1;
            acc   = iv16 && ir16;
            xfer  = ov16 && or16;
            obs16 = o16;
            @(posedge clk);
            if (acc) begin
                q16.push_back(ref16(p16));
                sent++;
            end
            if (xfer) begin
                chk("r16_expected_pending", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    // First result is 16'h4000: k=0, exp=0, hidden bit alone at mantissa MSB.
                    if (got == 0) chk("r16_4000", 32'(obs16), 32'({1'b0, 5'd0, 2'd0, 12'h800, 1'b0, 1'b0}));
                    chk($sformatf("r16_%0d", got), 32'(obs16), 32'(q16.pop_front()));
                end
                got++;
            end
        end
        iv16 = 1'b0;
        chk("r16_count", 32'(got), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
